// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: opcodes, control/pipeline types and field helpers for the decode stage
package id_pipe_pkg;
  localparam int PKG_XLEN = 32;
  typedef logic [31:0] instr_t;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  typedef enum logic [1:0] {RF_ALU, RF_MEM, RF_PC4, RF_IMM} rfmux_t;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_imm;
    rfmux_t     rfmux;
  } ctrl_t;
  typedef struct packed {
    logic                valid;
    logic [PKG_XLEN-1:0] pc;
    instr_t              instruction;
    ctrl_t               ctrl;
    logic [PKG_XLEN-1:0] rs1_data;
    logic [PKG_XLEN-1:0] rs2_data;
  } idex_t;
  function automatic logic is_load(instr_t i);
    return i[6:0] == OP_LOAD;
  endfunction
  function automatic logic [4:0] rd_of(instr_t i);
    return i[11:7];
  endfunction
  function automatic logic [4:0] rs1_of(instr_t i);
    return i[19:15];
  endfunction
  function automatic logic [4:0] rs2_of(instr_t i);
    return i[24:20];
  endfunction
  function automatic logic reg_ok(logic [4:0] idx, int n);
    return idx != '0 && 32'(idx) < n;
  endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID input, writeback and ID/EX output bundle of the decode stage
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  import id_pipe_pkg::*;
  logic            ifid_valid;
  instr_t          ifid_instruction;
  logic [XLEN-1:0] ifid_pc;
  logic            id_ready;
  logic            ex_ready;
  logic            flush;
  logic            memwb_load_regfile;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] wb_regfilemux_out;
  logic            idex_valid;
  logic [XLEN-1:0] idex_pc;
  instr_t          idex_instruction;
  ctrl_t           idex_ctrl;
  logic [XLEN-1:0] idex_rs1_data;
  logic [XLEN-1:0] idex_rs2_data;
  modport master (
    output ifid_valid, ifid_instruction, ifid_pc, ex_ready, flush,
    output memwb_load_regfile, memwb_rd, wb_regfilemux_out,
    input  id_ready, idex_valid, idex_pc, idex_instruction, idex_ctrl, idex_rs1_data, idex_rs2_data
  );
  modport slave (
    input  ifid_valid, ifid_instruction, ifid_pc, ex_ready, flush,
    input  memwb_load_regfile, memwb_rd, wb_regfilemux_out,
    output id_ready, idex_valid, idex_pc, idex_instruction, idex_ctrl, idex_rs1_data, idex_rs2_data
  );
endinterface

// File: rtl/id_stage_pipe_ctrl_rom.sv
// ctrl_rom: opcode decode into the control word carried down the pipeline
module ctrl_rom
  import id_pipe_pkg::*;
(
  input  instr_t instr,
  output ctrl_t  ctrl
);
  logic [6:0] op;
  logic       jump;
  assign op = instr[6:0];
  assign jump = op == OP_JAL || op == OP_JALR;
  // field extraction plus per-opcode control bits
  always_comb begin
    ctrl = '0;
    ctrl.opcode = op;
    ctrl.rd = instr[11:7];
    ctrl.funct3 = instr[14:12];
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    ctrl.funct7 = instr[31:25];
    ctrl.load_regfile = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    ctrl.mem_read = op == OP_LOAD;
    ctrl.mem_write = op == OP_STORE;
    ctrl.branch = op == OP_BR;
    ctrl.jump = jump;
    ctrl.alu_imm = op inside {OP_AUIPC, OP_JALR, OP_LOAD, OP_STORE, OP_IMM};
    ctrl.rfmux = op == OP_LOAD ? RF_MEM : jump ? RF_PC4 : op == OP_LUI ? RF_IMM : RF_ALU;
  end
endmodule

// File: rtl/id_stage_pipe_regfile.sv
// regfile_param: 1W/2R register file, x0 and out-of-range indices read 0; ID_WB_BYPASS_EN adds write-through
module regfile_param
  import id_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int REG_AW = $clog2(NUM_REGS);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr;
  assign wr = we && reg_ok(wa, NUM_REGS);
  // write port; x0 and indices beyond NUM_REGS are silently dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wr) regs[wa[REG_AW-1:0]] <= wd;
  // async read ports, optionally returning the same-cycle writeback
  always_comb begin
`ifdef ID_WB_BYPASS_EN
    rd1 = wr && wa == ra1 ? wd : reg_ok(ra1, NUM_REGS) ? regs[ra1[REG_AW-1:0]] : '0;
    rd2 = wr && wa == ra2 ? wd : reg_ok(ra2, NUM_REGS) ? regs[ra2[REG_AW-1:0]] : '0;
`else
    rd1 = reg_ok(ra1, NUM_REGS) ? regs[ra1[REG_AW-1:0]] : '0;
    rd2 = reg_ok(ra2, NUM_REGS) ? regs[ra2[REG_AW-1:0]] : '0;
`endif
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with ID/EX register and hazard control; ID_WB_BYPASS_EN replaces the writeback stall with write-through
module id_stage_pipe
  import id_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input logic            clk,
  input logic            rst_n,
  id_stage_pipe_if.slave bus
);
  idex_t           idex;
  ctrl_t           ctrl;
  logic [4:0]      rs1, rs2, ex_rd;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            adv, hazard_lu, hazard, id_ready, xfer;
  if (XLEN != PKG_XLEN) begin : g_xlen
    $error("id_stage_pipe: XLEN must match PKG_XLEN");
  end
  assign rs1 = rs1_of(bus.ifid_instruction);
  assign rs2 = rs2_of(bus.ifid_instruction);
  assign ex_rd = rd_of(idex.instruction);
  ctrl_rom u_ctrl (
    .instr(bus.ifid_instruction),
    .ctrl (ctrl)
  );
  regfile_param #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
    .clk,
    .rst_n,
    .we (bus.memwb_load_regfile),
    .wa (bus.memwb_rd),
    .wd (bus.wb_regfilemux_out),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rs1_data),
    .rd2(rs2_data)
  );
  // hazard detection and handshake; rs fields are compared raw, so some formats stall needlessly
  always_comb begin
    adv = !idex.valid || bus.ex_ready;
    hazard_lu = idex.valid && is_load(idex.instruction) && ex_rd != '0 && (ex_rd == rs1 || ex_rd == rs2);
`ifdef ID_WB_BYPASS_EN
    hazard = hazard_lu;
`else
    hazard = hazard_lu || (bus.ifid_valid && bus.memwb_load_regfile && bus.memwb_rd != '0 &&
                           (bus.memwb_rd == rs1 || bus.memwb_rd == rs2));
`endif
    id_ready = adv && !hazard && !bus.flush;
    xfer = bus.ifid_valid && id_ready;
  end
  // ID/EX register: flush kills, a stall holds, otherwise capture or insert a bubble keeping the payload
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idex <= '0;
    else if (bus.flush) idex.valid <= 1'b0;
    else if (adv) begin
      idex.valid <= xfer;
      if (xfer) begin
        idex.pc <= bus.ifid_pc;
        idex.instruction <= bus.ifid_instruction;
        idex.ctrl <= ctrl;
        idex.rs1_data <= rs1_data;
        idex.rs2_data <= rs2_data;
      end
    end
  assign bus.id_ready = id_ready;
  assign bus.idex_valid = idex.valid;
  assign bus.idex_pc = idex.pc;
  assign bus.idex_instruction = idex.instruction;
  assign bus.idex_ctrl = idex.ctrl;
  assign bus.idex_rs1_data = idex.rs1_data;
  assign bus.idex_rs2_data = idex.rs2_data;
endmodule
